// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle CPU: fetch FSM encoding and datapath constants.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    REQ     = 2'b01,
    WAIT    = 2'b10,
    DELIVER = 2'b11
  } fetch_state_t;

  localparam int unsigned INSTR_W          = 32;
  localparam int unsigned PC_STEP          = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_reg.sv
// Program counter register: async active-low reset, load enable, word-aligned load.
module pc_reg
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] pc_in,
  output logic [31:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pc <= RESET_PC;
    else if (load)
      pc <= {pc_in[31:2], 2'b00};
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC ownership, imem req/gnt/rvalid handshake, IR write strobe.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               fetchStart,
  input  logic               PCWre,
  input  logic [31:0]        pcNext,
  output logic               imemReq,
  output logic [31:0]        imemAddr,
  input  logic               imemGnt,
  input  logic               imemRvalid,
  input  logic [INSTR_W-1:0] imemRdata,
  output logic [INSTR_W-1:0] instructionOut,
  output logic               IRWre,
  output logic               fetchDone,
  output logic               fetchErr,
  output logic [31:0]        curPC,
  output logic [31:0]        pcPlus4,
  output logic               fetchBusy
);

  fetch_state_t state, next_state;
  logic [7:0]   wait_cnt;
  logic         capture;
  logic         timeout;

  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk   (CLK),
    .rst_n (RST),
    .load  (PCWre && (state == IDLE)),
    .pc_in (pcNext),
    .pc    (curPC)
  );

  assign pcPlus4   = curPC + 32'(PC_STEP);
  assign imemAddr  = imemReq ? curPC : '0;
  assign fetchBusy = (state != IDLE);

  always_comb begin
    next_state = state;
    capture    = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE:    if (fetchStart) next_state = REQ;
      REQ: begin
        if (imemGnt) begin
          if (imemRvalid) begin
            capture    = 1'b1;
            next_state = DELIVER;
          end else begin
            next_state = WAIT;
          end
        end
      end
      WAIT: begin
        if (imemRvalid) begin
          capture    = 1'b1;
          next_state = DELIVER;
        end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
          timeout    = 1'b1;
          next_state = IDLE;
        end
      end
      DELIVER: next_state = IDLE;
    endcase
  end

  // Strobes are registered from next_state so they align with the state they belong to.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      instructionOut <= '0;
      imemReq        <= 1'b0;
      IRWre          <= 1'b0;
      fetchDone      <= 1'b0;
      fetchErr       <= 1'b0;
    end else begin
      state     <= next_state;
      imemReq   <= (next_state == REQ);
      IRWre     <= (next_state == DELIVER);
      fetchDone <= (next_state == DELIVER);
      if (capture)
        instructionOut <= imemRdata;
      if (state == WAIT && !imemRvalid && !timeout)
        wait_cnt <= wait_cnt + 8'd1;
      else
        wait_cnt <= '0;
      if (state == IDLE && next_state == REQ)
        fetchErr <= 1'b0;
      else if (timeout)
        fetchErr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit with RESET_PC = 0x100, TIMEOUT = 16.
module tb_instr_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        fetchStart = 1'b0;
  logic        PCWre = 1'b0;
  logic [31:0] pcNext = '0;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemGnt = 1'b0;
  logic        imemRvalid = 1'b0;
  logic [31:0] imemRdata = '0;
  logic [31:0] instructionOut;
  logic        IRWre;
  logic        fetchDone;
  logic        fetchErr;
  logic [31:0] curPC;
  logic [31:0] pcPlus4;
  logic        fetchBusy;

  int unsigned compared = 0;
  int unsigned mismatched = 0;

  instr_fetch_unit #(.RESET_PC(32'h0000_0100), .TIMEOUT(16)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .fetchStart     (fetchStart),
    .PCWre          (PCWre),
    .pcNext         (pcNext),
    .imemReq        (imemReq),
    .imemAddr       (imemAddr),
    .imemGnt        (imemGnt),
    .imemRvalid     (imemRvalid),
    .imemRdata      (imemRdata),
    .instructionOut (instructionOut),
    .IRWre          (IRWre),
    .fetchDone      (fetchDone),
    .fetchErr       (fetchErr),
    .curPC          (curPC),
    .pcPlus4        (pcPlus4),
    .fetchBusy      (fetchBusy)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_strobes(input string tag);
    check({tag, ".imemReq"},   32'(imemReq),   32'd0);
    check({tag, ".IRWre"},     32'(IRWre),     32'd0);
    check({tag, ".fetchDone"}, 32'(fetchDone), 32'd0);
    check({tag, ".fetchBusy"}, 32'(fetchBusy), 32'd0);
  endtask

  initial begin
    // Reset state
    #12;
    check("rst.curPC",   curPC,   32'h0000_0100);
    check("rst.pcPlus4", pcPlus4, 32'h0000_0104);
    check("rst.instr",   instructionOut, 32'h0);
    check("rst.fetchErr", 32'(fetchErr), 32'd0);
    check_idle_strobes("rst");
    @(negedge CLK);
    RST = 1'b1;
    step();

    // Normal fetch: grant in cycle 1, response in cycle 2, deliver in cycle 3
    fetchStart = 1'b1;
    step();
    check("f1.c1.imemReq",  32'(imemReq),   32'd1);
    check("f1.c1.imemAddr", imemAddr,       32'h0000_0100);
    check("f1.c1.busy",     32'(fetchBusy), 32'd1);
    check("f1.c1.IRWre",    32'(IRWre),     32'd0);
    fetchStart = 1'b0;
    imemGnt    = 1'b1;
    step();
    check("f1.c2.imemReq", 32'(imemReq), 32'd0);
    check("f1.c2.IRWre",   32'(IRWre),   32'd0);
    imemGnt    = 1'b0;
    imemRvalid = 1'b1;
    imemRdata  = 32'h0221_8020;
    step();
    check("f1.c3.IRWre",     32'(IRWre),     32'd1);
    check("f1.c3.fetchDone", 32'(fetchDone), 32'd1);
    check("f1.c3.instr",     instructionOut, 32'h0221_8020);
    imemRvalid = 1'b0;
    imemRdata  = '0;
    step();
    check_idle_strobes("f1.c4");
    check("f1.c4.instr", instructionOut, 32'h0221_8020);

    // Grant and response in the same cycle: IRWre two cycles after fetchStart
    fetchStart = 1'b1;
    step();
    check("f2.c1.imemReq", 32'(imemReq), 32'd1);
    fetchStart = 1'b0;
    imemGnt    = 1'b1;
    imemRvalid = 1'b1;
    imemRdata  = 32'h8C22_0004;
    step();
    check("f2.c2.IRWre",     32'(IRWre),     32'd1);
    check("f2.c2.fetchDone", 32'(fetchDone), 32'd1);
    check("f2.c2.instr",     instructionOut, 32'h8C22_0004);
    imemGnt    = 1'b0;
    imemRvalid = 1'b0;
    step();
    check_idle_strobes("f2.c3");

    // PC load in IDLE masks the low bits
    PCWre  = 1'b1;
    pcNext = 32'h0000_0207;
    step();
    check("pcld.curPC",   curPC,   32'h0000_0204);
    check("pcld.pcPlus4", pcPlus4, 32'h0000_0208);
    PCWre = 1'b0;

    // Fetch at new PC; PCWre during WAIT ignored; then time out
    fetchStart = 1'b1;
    step();
    check("f3.imemAddr", imemAddr, 32'h0000_0204);
    fetchStart = 1'b0;
    imemGnt    = 1'b1;
    step();
    imemGnt = 1'b0;
    PCWre   = 1'b1;
    pcNext  = 32'h0000_0300;
    step();
    check("f3.wait.curPC", curPC, 32'h0000_0204);
    PCWre = 1'b0;
    for (int i = 3; i <= 16; i++) step();
    check("to.w16.busy",     32'(fetchBusy), 32'd1);
    check("to.w16.fetchErr", 32'(fetchErr),  32'd0);
    step();
    check("to.fetchErr", 32'(fetchErr),  32'd1);
    check("to.busy",     32'(fetchBusy), 32'd0);
    check("to.IRWre",    32'(IRWre),     32'd0);
    check("to.instr",    instructionOut, 32'h8C22_0004);

    // Next fetch clears fetchErr on entering REQ
    fetchStart = 1'b1;
    step();
    check("f4.fetchErr", 32'(fetchErr), 32'd0);
    check("f4.imemReq",  32'(imemReq),  32'd1);
    fetchStart = 1'b0;
    imemGnt    = 1'b1;
    step();
    imemGnt = 1'b0;

    // Asynchronous reset in WAIT, then a late response after release
    #2;
    RST = 1'b0;
    #1;
    check("arst.curPC", curPC, 32'h0000_0100);
    check("arst.instr", instructionOut, 32'h0);
    check("arst.fetchErr", 32'(fetchErr), 32'd0);
    check_idle_strobes("arst");
    @(negedge CLK);
    RST        = 1'b1;
    imemRvalid = 1'b1;
    imemRdata  = 32'hDEAD_BEEF;
    step();
    check("late.IRWre", 32'(IRWre), 32'd0);
    check("late.busy",  32'(fetchBusy), 32'd0);
    imemRvalid = 1'b0;
    step();
    check("late2.IRWre", 32'(IRWre), 32'd0);
    check("late2.instr", instructionOut, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch front end of the multicycle CPU: owns the program counter, runs a request/grant/response handshake with instruction memory, and writes the fetched word into the instruction register. It drives the IR's instruction input and its one-cycle `IRWre` write strobe. It is started once per instruction by the control unit's IF state and reports completion back to it.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value after reset.
- `TIMEOUT`, default 16: maximum number of cycles spent in WAIT without `imemRvalid` before the fetch aborts; range 2..255.
- `CLK` in 1: single clock; all state changes on the rising edge.
- `RST` in 1: asynchronous, active-low reset.
- `fetchStart` in 1: control unit requests one fetch; sampled only in IDLE.
- `PCWre` in 1: load `pcNext` into the PC; honoured only in IDLE.
- `pcNext` in 32: next PC (branch, jump or `pcPlus4`) from the datapath mux.
- `imemReq` out 1: instruction-memory request.
- `imemAddr` out 32: fetch address; equals `curPC` while `imemReq` is high.
- `imemGnt` in 1: memory accepts the request.
- `imemRvalid` in 1: `imemRdata` is valid this cycle.
- `imemRdata` in 32: instruction word.
- `instructionOut` out 32: registered instruction; connects to the IR data input.
- `IRWre` out 1: one-cycle IR write strobe.
- `fetchDone` out 1: one-cycle completion pulse, coincident with `IRWre`.
- `fetchErr` out 1: sticky timeout flag.
- `curPC` out 32: current PC.
- `pcPlus4` out 32: `curPC + 4`, combinational, modulo 2^32.
- `fetchBusy` out 1: high in every state except IDLE.

## Operation
- The FSM has four states: IDLE, REQ, WAIT and DELIVER.
- IDLE with `fetchStart`=1 goes to REQ. Entering REQ clears `fetchErr`.
- REQ drives `imemReq`=1 and `imemAddr`=`curPC`. The request is held until `imemGnt`=1.
  - `imemGnt`=1 with `imemRvalid`=0 goes to WAIT.
  - `imemGnt`=1 with `imemRvalid`=1 in the same cycle captures `imemRdata` and goes straight to DELIVER.
- WAIT drives `imemReq`=0 and counts cycles.
  - `imemRvalid`=1 captures `imemRdata` into `instructionOut` and goes to DELIVER.
  - When the counter reaches `TIMEOUT` without `imemRvalid`, the FSM sets `fetchErr`=1 and returns to IDLE. There is no `IRWre` and `instructionOut` is unchanged.
- DELIVER drives `IRWre`=1 and `fetchDone`=1 for exactly one cycle, then goes to IDLE.
- `instructionOut` holds its value between captures.
- PC load: `PCWre`=1 in IDLE loads `pcNext` with bits [1:0] forced to 00. `PCWre` in any other state is ignored, so the PC is stable for the whole fetch.
- `PCWre` and `fetchStart` together in IDLE: the PC loads and the FSM moves to REQ. The fetch uses the new PC.
- `fetchStart` outside IDLE is ignored.
- `imemRvalid` or `imemGnt` outside their consuming states is ignored.
- Reset, asynchronous and mid-operation included, forces:
  - state = IDLE
  - `curPC` = `RESET_PC`
  - `instructionOut` = 0
  - timeout counter = 0
  - `imemReq`, `IRWre`, `fetchDone`, `fetchErr` and `fetchBusy` all = 0
- A memory response still in flight when reset is released is dropped.

## Timing
- Cycle 0: `fetchStart` is sampled in IDLE.
- Cycle 1: REQ, `imemReq`=1. With `imemGnt`=1, WAIT follows in cycle 2.
- Cycle 2: `imemRvalid`=1.
- Cycle 3: DELIVER, `IRWre`=1.
- Minimum latency from `fetchStart` to `IRWre` is 2 cycles, when grant and response coincide in cycle 1.
- Back-to-back fetches: the next `fetchStart` may be asserted in the cycle after DELIVER.
- Outputs are registered except `pcPlus4`, `imemAddr` (mux of `curPC`) and `fetchBusy` (state decode).

## Structure
- A shared package `cpu_pkg` holds:
  - the state enum `fetch_state_t` (IDLE=2'b00, REQ=2'b01, WAIT=2'b10, DELIVER=2'b11)
  - `INSTR_W`=32
  - `PC_STEP`=4
  - `DEFAULT_RESET_PC`
- Sub-module `pc_reg` holds the PC register with its asynchronous active-low reset, load enable and bits [1:0] masking.
- The FSM, timeout counter and instruction capture register stay in the top module.

## Test plan
- Reset with `RESET_PC`=32'h0000_0100 → `curPC`=0x100, `pcPlus4`=0x104, all strobes 0, `instructionOut`=0.
- `fetchStart`; `imemGnt` in cycle 1; `imemRvalid` in cycle 2 with `imemRdata`=0x0221_8020 → `imemAddr`=0x100 in cycle 1, `IRWre`/`fetchDone` high only in cycle 3, `instructionOut`=0x0221_8020.
- Grant and response in the same cycle with data 0x8C22_0004 → `IRWre` 2 cycles after `fetchStart`.
- `PCWre` with `pcNext`=0x0000_0207 in IDLE → `curPC`=0x204. `PCWre` during WAIT → `curPC` unchanged.
- No `imemRvalid` for 16 cycles in WAIT → `fetchErr`=1, no `IRWre`, `instructionOut` holds its prior value. The next `fetchStart` clears `fetchErr`.
- `RST` low asynchronously in WAIT → all outputs are at reset values immediately. A late `imemRvalid` after release produces no `IRWre`.
